stack_ctrl: RTL and testbench

//  Command front end for one synapse stack_reg instance. Accepts push/pop/swap commands from the

---
 rtl/stack_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stack_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Command front end for a shift-only stack_reg: push/pop/swap sequencing, occupancy and errors.
// Optional high-water mark tracking is enabled by defining STACK_CTRL_WATERMARK_EN.
module stack_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       sysclk,
  input  logic                       sysreset_n,
  input  logic                       cmd_push,
  input  logic                       cmd_pop,
  input  logic [15:0]                cmd_data,
  output logic                       cmd_ready,
  input  logic                       clear_err,
  output logic                       stk_load,
  output logic                       stk_read,
  output logic [15:0]                stk_data_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic [$clog2(DEPTH+1)-1:0] hwm
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSwapPop,
    StSwapPush
  } state_e;

  state_e         state_q, state_d;
  logic           load_q, load_d;
  logic           read_q, read_d;
  logic [15:0]    data_q, data_d;
  logic [15:0]    swap_data_q, swap_data_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           ovf_set, unf_set;
  logic           is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthC);

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    read_d      = 1'b0;
    data_d      = data_q;
    swap_data_d = swap_data_q;
    count_d     = count_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;

    unique case (state_q)
      StIdle: begin
        unique case ({cmd_push, cmd_pop})
          2'b10: begin
            // A push while full still loads: stack_reg drops its bottom entry.
            load_d = 1'b1;
            data_d = cmd_data;
            if (is_full) begin
              ovf_set = 1'b1;
            end else begin
              count_d = count_q + OneC;
            end
          end
          2'b01: begin
            if (is_empty) begin
              unf_set = 1'b1;
            end else begin
              read_d  = 1'b1;
              count_d = count_q - OneC;
            end
          end
          2'b11: begin
            if (is_empty) begin
              // Nothing to replace: flag it and behave as a plain push.
              unf_set = 1'b1;
              load_d  = 1'b1;
              data_d  = cmd_data;
              count_d = count_q + OneC;
            end else begin
              read_d      = 1'b1;
              swap_data_d = cmd_data;
              state_d     = StSwapPop;
            end
          end
          default: ;
        endcase
      end
      StSwapPop: begin
        load_d  = 1'b1;
        data_d  = swap_data_q;
        state_d = StSwapPush;
      end
      StSwapPush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A same-cycle error event overrides clear_err.
  always_comb begin
    ovf_d = (ovf_q & ~clear_err) | ovf_set;
    unf_d = (unf_q & ~clear_err) | unf_set;
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      state_q     <= StIdle;
      load_q      <= 1'b0;
      read_q      <= 1'b0;
      data_q      <= '0;
      swap_data_q <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      read_q      <= read_d;
      data_q      <= data_d;
      swap_data_q <= swap_data_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

`ifdef STACK_CTRL_WATERMARK_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (clear_err) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  assign cmd_ready   = (state_q == StIdle);
  assign stk_load    = load_q;
  assign stk_read    = read_q;
  assign stk_data_in = data_q;
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (DEPTH=8) with a small shift-stack model standing in for
// stack_reg so the visible top entry can be checked.
module tb_stack_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          sysclk = 1'b0;
  logic          sysreset_n;
  logic          cmd_push, cmd_pop, clear_err;
  logic [15:0]   cmd_data;
  logic          cmd_ready, stk_load, stk_read, empty, full, err_ovf, err_unf;
  logic [15:0]   stk_data_in;
  logic [CW-1:0] count, hwm;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [DEPTH];
  logic [15:0] top;
  assign top = mdl[0];

  always #5 sysclk = ~sysclk;

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .sysclk      (sysclk),
    .sysreset_n  (sysreset_n),
    .cmd_push    (cmd_push),
    .cmd_pop     (cmd_pop),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .clear_err   (clear_err),
    .stk_load    (stk_load),
    .stk_read    (stk_read),
    .stk_data_in (stk_data_in),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf),
    .hwm         (hwm)
  );

  // Model of stack_reg: load shifts down (bottom lost), read shifts up.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] <= '0;
    end else if (stk_load) begin
      mdl[0] <= stk_data_in;
      for (int i = 1; i < DEPTH; i++) mdl[i] <= mdl[i-1];
    end else if (stk_read) begin
      for (int i = 0; i < DEPTH - 1; i++) mdl[i] <= mdl[i+1];
      mdl[DEPTH-1] <= '0;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_push  = 1'b0;
    cmd_pop   = 1'b0;
    cmd_data  = '0;
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sysreset_n = 1'b0;
    tick();
    tick();
    sysreset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_load", 32'(stk_load), 32'd0);
    chk("rst_read", 32'(stk_read), 32'd0);
    chk("rst_data", 32'(stk_data_in), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(err_ovf), 32'd0);
    chk("rst_unf", 32'(err_unf), 32'd0);
    chk("rst_hwm", 32'(hwm), 32'd0);
  endtask

  task automatic test_push();
    do_reset();
    cmd_push = 1'b1;
    cmd_data = 16'h1234;
    tick();
    idle_inputs();
    chk("push_load", 32'(stk_load), 32'd1);
    chk("push_data", 32'(stk_data_in), 32'h1234);
    chk("push_count", 32'(count), 32'd1);
    chk("push_read", 32'(stk_read), 32'd0);
    tick();
    chk("push_load_1cyc", 32'(stk_load), 32'd0);
    chk("push_top", 32'(top), 32'h1234);
  endtask

  task automatic test_overflow();
    int loads = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cmd_push = 1'b1;
      cmd_data = 16'(i);
      tick();
      if (stk_load) loads++;
    end
    idle_inputs();
    tick();
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_loads", 32'(loads), 32'd9);
    chk("ovf_top", 32'(top), 32'd9);
    for (int k = 1; k <= 8; k++) begin
      cmd_pop = 1'b1;
      tick();
      cmd_pop = 1'b0;
      chk("pop_strobe", 32'(stk_read), 32'd1);
      tick();
      if (k <= 7) chk("pop_top", 32'(top), 32'(9 - k));
    end
    chk("pop_empty", 32'(empty), 32'd1);
    chk("pop_count", 32'(count), 32'd0);
    chk("pop_unf", 32'(err_unf), 32'd0);
  endtask

  task automatic test_underflow();
    do_reset();
    cmd_pop = 1'b1;
    tick();
    cmd_pop = 1'b0;
    chk("unf_noread", 32'(stk_read), 32'd0);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_flag", 32'(err_unf), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("unf_clear", 32'(err_unf), 32'd0);
    // Error event in the same cycle as clear_err keeps the flag set.
    cmd_pop   = 1'b1;
    clear_err = 1'b1;
    tick();
    idle_inputs();
    chk("unf_wins_clear", 32'(err_unf), 32'd1);
  endtask

  task automatic test_swap();
    do_reset();
    cmd_push = 1'b1;
    cmd_data = 16'hAAAA;
    tick();
    idle_inputs();
    tick();
    cmd_push = 1'b1;
    cmd_pop  = 1'b1;
    cmd_data = 16'h5555;
    tick();
    // In SWAP_POP: present a push that must be ignored.
    cmd_pop  = 1'b0;
    cmd_data = 16'h7777;
    chk("swap_ready0", 32'(cmd_ready), 32'd0);
    chk("swap_read", 32'(stk_read), 32'd1);
    chk("swap_noload", 32'(stk_load), 32'd0);
    tick();
    idle_inputs();
    chk("swap_ready1", 32'(cmd_ready), 32'd0);
    chk("swap_load", 32'(stk_load), 32'd1);
    chk("swap_noread", 32'(stk_read), 32'd0);
    chk("swap_data", 32'(stk_data_in), 32'h5555);
    tick();
    chk("swap_ready_back", 32'(cmd_ready), 32'd1);
    chk("swap_load_done", 32'(stk_load), 32'd0);
    chk("swap_count", 32'(count), 32'd1);
    chk("swap_top", 32'(top), 32'h5555);
    chk("swap_unf", 32'(err_unf), 32'd0);
  endtask

  task automatic test_swap_empty();
    do_reset();
    cmd_push = 1'b1;
    cmd_pop  = 1'b1;
    cmd_data = 16'hBEEF;
    tick();
    idle_inputs();
    chk("swape_count", 32'(count), 32'd1);
    chk("swape_unf", 32'(err_unf), 32'd1);
    chk("swape_ready", 32'(cmd_ready), 32'd1);
    chk("swape_load", 32'(stk_load), 32'd1);
    chk("swape_data", 32'(stk_data_in), 32'hBEEF);
  endtask

  task automatic test_reset_mid_swap();
    do_reset();
    cmd_push = 1'b1;
    cmd_data = 16'h1111;
    tick();
    idle_inputs();
    tick();
    cmd_push = 1'b1;
    cmd_pop  = 1'b1;
    cmd_data = 16'h2222;
    tick();
    idle_inputs();
    chk("rms_in_swap", 32'(cmd_ready), 32'd0);
    sysreset_n = 1'b0;
    tick();
    sysreset_n = 1'b1;
    chk("rms_ready", 32'(cmd_ready), 32'd1);
    chk("rms_noload", 32'(stk_load), 32'd0);
    chk("rms_noread", 32'(stk_read), 32'd0);
    chk("rms_count", 32'(count), 32'd0);
  endtask

  task automatic test_watermark();
    logic [CW-1:0] exp_hwm_peak, exp_hwm_clr;
`ifdef STACK_CTRL_WATERMARK_EN
    exp_hwm_peak = CW'(5);
    exp_hwm_clr  = CW'(2);
`else
    exp_hwm_peak = '0;
    exp_hwm_clr  = '0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_push = 1'b1;
      cmd_data = 16'(16'h100 + i);
      tick();
    end
    cmd_push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_pop = 1'b1;
      tick();
    end
    idle_inputs();
    chk("wm_count", 32'(count), 32'd2);
    chk("wm_peak", 32'(hwm), 32'(exp_hwm_peak));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("wm_clear", 32'(hwm), 32'(exp_hwm_clr));
  endtask

  initial begin
    idle_inputs();
    sysreset_n = 1'b0;
    test_reset();
    test_push();
    test_overflow();
    test_underflow();
    test_swap();
    test_swap_empty();
    test_reset_mid_swap();
    test_watermark();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
